// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multicycle controller.
//   mc_state_t  - instruction-sequencing FSM states
//   ALU_*       - ALUControl encodings
//   SRCB_*      - ALUSrcB encodings
//   RES_*       - ResultSrc encodings
//   OP_*        - instruction Op field classes
//   mc_ctrl_t   - per-state Moore control bundle
//   state_ctrl  - maps a state to its control bundle
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } mc_state_t;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_ORR = 4'd3;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
  } mc_ctrl_t;

  // Anything not set for a state stays 0 (strobes off, selects at encoding 0).
  function automatic mc_ctrl_t state_ctrl(input mc_state_t s);
    mc_ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.next_pc    = 1'b1;
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
      end
      S_MEMADR: c.alu_src_b = SRCB_IMM;
      S_MEMRD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_b = SRCB_REG;
        c.alu_op    = 1'b1;
      end
      S_EXECI: begin
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = 1'b1;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_w      = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_b  = SRCB_IMM;
        c.result_src = RES_ALURESULT;
        c.branch     = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cond_unit.sv
// cond_unit: N/Z/C/V flag register, condition evaluation and write gating.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   cond       [3:0]      instruction condition field
//   alu_flags  [3:0]      {N,Z,C,V} from the ALU this cycle
//   flag_w     [1:0]      [1] update N/Z, [0] update C/V (only nonzero while executing)
//   latch_cond            high in DECODE; captures the condition result
//   next_pc, reg_w, mem_w, pcs   ungated write requests
//   pc_write, reg_write, mem_write  gated strobes to the datapath
module cond_unit
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       latch_cond,
  input  logic       next_pc,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       pcs,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write
);

  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;
  logic       cond_ex;
  logic       flag_n, flag_z, flag_c, flag_v;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = ~(flag_n ^ flag_v);
      4'b1011: cond_ex = flag_n ^ flag_v;
      4'b1100: cond_ex = ~flag_z & ~(flag_n ^ flag_v);
      4'b1101: cond_ex = flag_z | (flag_n ^ flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Flag writes honour the latched condition, so a failing SUBS leaves flags alone.
  always_comb begin
    flags_d = flags_q;
    if (flag_w[1] & condex_q) flags_d[3:2] = alu_flags[3:2];
    if (flag_w[0] & condex_q) flags_d[1:0] = alu_flags[1:0];
    condex_d = latch_cond ? cond_ex : condex_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  // rst_n gating keeps the strobes low for the whole reset, not just from the next edge.
  assign reg_write = reg_w & condex_q & rst_n;
  assign mem_write = mem_w & condex_q & rst_n;
  assign pc_write  = (next_pc | (pcs & condex_q)) & rst_n;

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control unit for the multicycle ARM-subset datapath.
// Sequences FETCH/DECODE/address/execute/write-back and decodes the ALU op.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   Cond[3:0] Op[1:0] Funct[5:0] Rd[3:0]   instruction register fields
//   ALUFlags[3:0]                     {N,Z,C,V} from the ALU
//   PCWrite MemWrite RegWrite IRWrite datapath write strobes
//   AdrSrc ALUSrcA ALUSrcB ResultSrc  datapath mux selects (Moore)
//   ImmSrc RegSrc ALUControl          combinational decodes of the fields
module multicycle_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] ALUControl
);

  mc_state_t  state_q, state_d;
  mc_ctrl_t   ctrl_q, ctrl_d;
  logic [1:0] flag_w;
  logic       pcs;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_DP:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
    // Controls are registered alongside the state, so they always match state_q.
    ctrl_d = state_ctrl(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Unrecognised Funct[4:1] decodes to ADD with no flag writes.
  always_comb begin
    ALUControl = ALU_ADD;
    flag_w     = 2'b00;
    if (ctrl_q.alu_op) begin
      case (Funct[4:1])
        4'b0100: begin
          ALUControl = ALU_ADD;
          flag_w     = {Funct[0], Funct[0]};
        end
        4'b0010: begin
          ALUControl = ALU_SUB;
          flag_w     = {Funct[0], Funct[0]};
        end
        4'b0000: begin
          ALUControl = ALU_AND;
          flag_w     = {Funct[0], 1'b0};
        end
        4'b1100: begin
          ALUControl = ALU_ORR;
          flag_w     = {Funct[0], 1'b0};
        end
        default: ;
      endcase
    end
  end

  // STR needs Rd on the second register read port; branches read PC as Rn.
  always_comb begin
    ImmSrc = 2'b00;
    RegSrc = 2'b00;
    case (Op)
      OP_MEM: begin
        ImmSrc = 2'b01;
        RegSrc = Funct[0] ? 2'b00 : 2'b10;
      end
      OP_BR: begin
        ImmSrc = 2'b10;
        RegSrc = 2'b01;
      end
      default: ;
    endcase
  end

  assign pcs       = ((Rd == 4'd15) & ctrl_q.reg_w) | ctrl_q.branch;
  assign IRWrite   = ctrl_q.ir_write & rst_n;
  assign AdrSrc    = ctrl_q.adr_src;
  assign ALUSrcA   = ctrl_q.alu_src_a;
  assign ALUSrcB   = ctrl_q.alu_src_b;
  assign ResultSrc = ctrl_q.result_src;

  cond_unit u_cond_unit (
    .clk        (clk),
    .rst_n      (rst_n),
    .cond       (Cond),
    .alu_flags  (ALUFlags),
    .flag_w     (flag_w),
    .latch_cond (state_q == S_DECODE),
    .next_pc    (ctrl_q.next_pc),
    .reg_w      (ctrl_q.reg_w),
    .mem_w      (ctrl_q.mem_w),
    .pcs        (pcs),
    .pc_write   (PCWrite),
    .reg_write  (RegWrite),
    .mem_write  (MemWrite)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed and randomized instruction streams checked
// cycle by cycle against an instruction-level reference model of the controller.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] Cond = 4'hE;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b0;
  logic [3:0] Rd = 4'h0;
  logic [3:0] ALUFlags = 4'h0;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [3:0] ALUControl;

  int         tests_run = 0;
  int         tests_failed = 0;
  logic [3:0] m_flags = 4'b0000;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Cond       (Cond),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,RegSrc,ALUControl}
  function automatic logic [17:0] obs_vec();
    return {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
            ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};
  endfunction

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int latency(input logic [1:0] op, input logic [5:0] funct);
    case (op)
      2'b00:   return 4;
      2'b01:   return funct[0] ? 5 : 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  // Returns -1 for Funct[4:1] patterns that are not ADD/SUB/AND/ORR.
  function automatic int alu_cmd(input logic [3:0] f41);
    case (f41)
      4'b0100: return 0;
      4'b0010: return 1;
      4'b0000: return 2;
      4'b1100: return 3;
      default: return -1;
    endcase
  endfunction

  // Expected outputs for cycle 'cyc' of an instruction, cycle 0 being its fetch.
  function automatic logic [17:0] exp_vec(input logic [1:0] op, input logic [5:0] funct,
                                          input logic [3:0] rd, input bit pass, input int cyc);
    logic pcw, memw, regw, irw, adr, srca;
    logic [1:0] srcb, res, imm, rsrc;
    logic [3:0] aluc;
    int cmd;
    {pcw, memw, regw, irw, adr, srca} = 6'b0;
    srcb = 2'd0; res = 2'd0; imm = 2'd0; rsrc = 2'd0; aluc = 4'd0;
    if (op == 2'b01) begin
      imm = 2'b01;
      rsrc = funct[0] ? 2'b00 : 2'b10;
    end else if (op == 2'b10) begin
      imm = 2'b10;
      rsrc = 2'b01;
    end
    if (cyc == 0) begin
      irw = 1'b1; pcw = 1'b1; srca = 1'b1; srcb = 2'd2; res = 2'd2;
    end else if (cyc == 1) begin
      srca = 1'b1; srcb = 2'd2; res = 2'd2;
    end else begin
      case (op)
        2'b00: begin
          if (cyc == 2) begin
            srcb = funct[5] ? 2'd1 : 2'd0;
            cmd = alu_cmd(funct[4:1]);
            aluc = (cmd < 0) ? 4'd0 : 4'(cmd);
          end else begin
            regw = pass; pcw = pass && (rd == 4'd15); res = 2'd0;
          end
        end
        2'b01: begin
          if (cyc == 2) srcb = 2'd1;
          else if (cyc == 3) begin
            adr = 1'b1; memw = pass && !funct[0];
          end else begin
            res = 2'd1; regw = pass; pcw = pass && (rd == 4'd15);
          end
        end
        2'b10: begin
          srcb = 2'd1; res = 2'd2; pcw = pass;
        end
        default: ;
      endcase
    end
    return {pcw, memw, regw, irw, adr, srca, srcb, res, imm, rsrc, aluc};
  endfunction

  // Runs one instruction starting just after the edge that enters its fetch.
  // abort_cyc >= 0 pulses reset in that cycle and checks the strobes drop at once.
  task automatic applyStimulus(input string name, input logic [3:0] cond, input logic [1:0] op,
                               input logic [5:0] funct, input logic [3:0] rd,
                               input logic [3:0] exec_flags, input int abort_cyc);
    int lat, cmd;
    bit pass;
    Cond = cond; Op = op; Funct = funct; Rd = rd;
    pass = cond_holds(cond, m_flags);
    lat = latency(op, funct);
    for (int cyc = 0; cyc < lat; cyc++) begin
      ALUFlags = (op == 2'b00 && cyc == 2) ? exec_flags : 4'($urandom);
      @(negedge clk);
      checkOutput($sformatf("%s c%0d", name, cyc), {14'b0, obs_vec()},
                  {14'b0, exp_vec(op, funct, rd, pass, cyc)});
      if (cyc == abort_cyc) begin
        #1 rst_n = 1'b0;
        #1 checkOutput($sformatf("%s reset strobes", name),
                       {28'b0, PCWrite, MemWrite, RegWrite, IRWrite}, 32'd0);
        m_flags = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
      if (op == 2'b00 && cyc == 2) begin
        cmd = alu_cmd(funct[4:1]);
        if (cmd >= 0 && funct[0] && pass) begin
          m_flags[3:2] = exec_flags[3:2];
          if (cmd <= 1) m_flags[1:0] = exec_flags[1:0];
        end
      end
    end
  endtask

  initial begin
    int lat, abort_at;
    logic [3:0] rc, rrd;
    logic [1:0] rop;
    logic [5:0] rfn;

    #12 checkOutput("reset strobes", {28'b0, PCWrite, MemWrite, RegWrite, IRWrite}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    applyStimulus("ADD imm",    4'hE, 2'b00, 6'b101000, 4'd1,  4'b1111, -1);
    applyStimulus("BEQ noflag", 4'h0, 2'b10, 6'b100000, 4'd0,  4'b0000, -1);
    applyStimulus("SUBS",       4'hE, 2'b00, 6'b000101, 4'd0,  4'b0110, -1);
    applyStimulus("ADDEQ",      4'h0, 2'b00, 6'b101000, 4'd2,  4'b0000, -1);
    applyStimulus("ADDNE",      4'h1, 2'b00, 6'b101000, 4'd2,  4'b0000, -1);
    applyStimulus("LDR",        4'hE, 2'b01, 6'b011001, 4'd3,  4'b0000, -1);
    applyStimulus("STR",        4'hE, 2'b01, 6'b011000, 4'd3,  4'b0000, -1);
    applyStimulus("B AL",       4'hE, 2'b10, 6'b100000, 4'd0,  4'b0000, -1);
    applyStimulus("B NV",       4'hF, 2'b10, 6'b100000, 4'd0,  4'b0000, -1);
    applyStimulus("ADD pc",     4'hE, 2'b00, 6'b101000, 4'd15, 4'b0000, -1);
    applyStimulus("bad funct",  4'hE, 2'b00, 6'b011111, 4'd4,  4'b1111, -1);
    applyStimulus("BCS",        4'h2, 2'b10, 6'b100000, 4'd0,  4'b0000, -1);
    applyStimulus("BVS",        4'h6, 2'b10, 6'b100000, 4'd0,  4'b0000, -1);
    applyStimulus("NOP op11",   4'hE, 2'b11, 6'b000000, 4'd0,  4'b0000, -1);
    applyStimulus("LDR abort",  4'hE, 2'b01, 6'b011001, 4'd5,  4'b0000, 3);
    applyStimulus("BNE post",   4'h1, 2'b10, 6'b100000, 4'd0,  4'b0000, -1);
    applyStimulus("SUBS again", 4'hE, 2'b00, 6'b000101, 4'd0,  4'b0110, -1);
    applyStimulus("STR abort",  4'hE, 2'b01, 6'b011000, 4'd5,  4'b0000, 3);
    applyStimulus("BEQ post",   4'h0, 2'b10, 6'b100000, 4'd0,  4'b0000, -1);
    applyStimulus("ADD abortF", 4'hE, 2'b00, 6'b101000, 4'd1,  4'b0000, 0);

    for (int i = 0; i < 300; i++) begin
      rop = 2'($urandom_range(0, 3));
      rfn = 6'($urandom);
      if (rop == 2'b00 && $urandom_range(0, 1) == 1)
        rfn[4:1] = 4'(($urandom_range(0, 3) == 0) ? 4'b0100 :
                      ($urandom_range(0, 2) == 0) ? 4'b0010 :
                      ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'b1100);
      rc  = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom);
      rrd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      lat = latency(rop, rfn);
      abort_at = (i % 50 == 49) ? $urandom_range(0, lat - 1) : -1;
      applyStimulus($sformatf("rnd%0d", i), rc, rop, rfn, rrd, 4'($urandom), abort_at);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
